// File: rtl/relu_pool.sv
// relu_pool: reads pairs of 64-bit words from a source BRAM, takes the
// lane-wise signed maximum of each pair, clamps negatives to zero (ReLU)
// and writes one result word per pair to a destination BRAM.
// Four cycles per pair: RDA, RDB, WAIT, WR.
module relu_pool #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [ADDR_W-1:0]    dst_base,
  input  logic [10:0]          pair_cnt,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [8*LANES-1:0]   rd_dout,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [8*LANES-1:0]   wr_din,
  output logic                 busy,
  output logic                 done
);

  localparam int DATA_W = 8;
  localparam int WORD_W = DATA_W * LANES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    WAIT = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [10:0]         cnt_q;
  logic [10:0]         j;
  logic [10:0]         j_inc;
  logic [WORD_W-1:0]   word_a;

  // Clamp a signed lane value at zero.
  function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    if (x < 0) begin
      return '0;
    end
    return x;
  endfunction

  // Lane-wise signed max of two words followed by ReLU.
  function automatic logic [WORD_W-1:0] pool_word(input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
    logic signed [DATA_W-1:0] la;
    logic signed [DATA_W-1:0] lb;
    logic signed [DATA_W-1:0] m;
    logic [WORD_W-1:0]        r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*DATA_W +: DATA_W];
      lb = b[i*DATA_W +: DATA_W];
      m  = (la > lb) ? la : lb;
      r[i*DATA_W +: DATA_W] = relu(m);
    end
    return r;
  endfunction

  assign j_inc = j + 11'd1;

  // Sequencer: all outputs are registered and take the value belonging to
  // the state being entered, so each state drives its own outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      j       <= '0;
      word_a  <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_din  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_base;
            dst_q <= dst_base;
            cnt_q <= pair_cnt;
            j     <= '0;
            busy  <= 1'b1;
            if (pair_cnt == 11'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RDA;
              rd_en   <= 1'b1;
              rd_addr <= src_base;
            end
          end
        end
        // ---- stage: second read of the pair (src + 2j + 1)
        RDA: begin
          state   <= RDB;
          rd_en   <= 1'b1;
          rd_addr <= src_q + ADDR_W'({j, 1'b1});
        end
        // ---- stage: word A arrives from the first read
        RDB: begin
          word_a <= rd_dout;
          state  <= WAIT;
        end
        // ---- stage: word B arrives and feeds the pooling function directly
        WAIT: begin
          state   <= WR;
          wr_en   <= 1'b1;
          wr_addr <= dst_q + ADDR_W'(j);
          wr_din  <= pool_word(word_a, rd_dout);
        end
        // ---- stage: write cycle; either finish or start the next pair
        WR: begin
          if (j_inc == cnt_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            j       <= j_inc;
            state   <= RDA;
            rd_en   <= 1'b1;
            rd_addr <= src_q + ADDR_W'({j_inc, 1'b0});
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_pool.sv
// Self-checking bench for relu_pool with a source BRAM model and a
// scoreboard of expected destination writes.
module tb_relu_pool;

  localparam int ADDR_W = 12;
  localparam int LANES  = 8;
  localparam int TMO    = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [11:0]       src_base = '0;
  logic [11:0]       dst_base = '0;
  logic [10:0]       pair_cnt = '0;
  logic              rd_en;
  logic [11:0]       rd_addr;
  logic [63:0]       rd_dout = '0;
  logic              wr_en;
  logic [11:0]       wr_addr;
  logic [63:0]       wr_din;
  logic              busy;
  logic              done;

  logic [63:0] mem [0:4095];

  logic [11:0] obs_rd[$];
  logic [11:0] obs_wa[$];
  logic [63:0] obs_wd[$];
  logic [11:0] exp_wa[$];
  logic [63:0] exp_wd[$];
  int          busy_cyc = 0;
  int          busy_rise = 0;
  logic        busy_q = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  relu_pool #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .pair_cnt (pair_cnt),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_dout  (rd_dout),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_din   (wr_din),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Source BRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_dout <= mem[rd_addr];
  end

  // Capture DUT activity mid-cycle.
  always @(negedge clk) begin
    if (rd_en) obs_rd.push_back(rd_addr);
    if (wr_en) begin
      obs_wa.push_back(wr_addr);
      obs_wd.push_back(wr_din);
    end
    if (busy) busy_cyc++;
    if (busy && !busy_q) busy_rise++;
    busy_q = busy;
  end

  function automatic logic [63:0] ref_pool(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int x, y, m;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      x = int'($signed(a[8*i +: 8]));
      y = int'($signed(b[8*i +: 8]));
      m = (x > y) ? x : y;
      if (m < 0) m = 0;
      r[8*i +: 8] = m[7:0];
    end
    return r;
  endfunction

  task automatic clear_obs();
    obs_rd.delete();
    obs_wa.delete();
    obs_wd.delete();
    exp_wa.delete();
    exp_wd.delete();
  endtask

  // Fill source words with random data and queue the expected writes.
  task automatic prep(input logic [11:0] src, input logic [11:0] dst, input int n);
    logic [11:0] a0, a1;
    clear_obs();
    for (int k = 0; k < 2*n; k++) begin
      a0 = src + 12'(k);
      mem[a0] = {$urandom(), $urandom()};
    end
    for (int p = 0; p < n; p++) begin
      a0 = src + 12'(2*p);
      a1 = a0 + 12'd1;
      exp_wa.push_back(dst + 12'(p));
      exp_wd.push_back(ref_pool(mem[a0], mem[a1]));
    end
  endtask

  // Pulse start and count rising edges from the accepting edge until done.
  task automatic run_pass(input logic [11:0] src, input logic [11:0] dst,
                          input logic [10:0] n, output int cyc, output bit tmo);
    @(negedge clk);
    src_base = src;
    dst_base = dst;
    pair_cnt = n;
    start    = 1'b1;
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rd_en, wr_en, done, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {rd_en, wr_en, done, busy});
    end
    n_tests++;
    if ({rd_addr, wr_addr} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 000000", {rd_addr, wr_addr});
    end
    n_tests++;
    if (wr_din !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_din: got %h expected 0", wr_din);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    bit tmo;
    clear_obs();
    mem[12'h010] = 64'h807F01FF0010F005;
    mem[12'h011] = 64'h7F8002FE000FF106;
    run_pass(12'h010, 12'h200, 11'd1, cyc, tmo);
    repeat (2) @(negedge clk);
    n_tests++;
    if (tmo || cyc !== 5) begin
      n_fail++;
      $display("FAIL single_latency: got %0d (tmo %0d) expected 5", cyc, tmo);
    end
    n_tests++;
    if (obs_rd.size() != 2 || obs_rd[0] !== 12'h010 || obs_rd[1] !== 12'h011) begin
      n_fail++;
      $display("FAIL single_reads: got %0d reads expected 2 at 010,011", obs_rd.size());
    end
    n_tests++;
    if (obs_wa.size() != 1) begin
      n_fail++;
      $display("FAIL single_wcount: got %0d expected 1", obs_wa.size());
    end else begin
      n_tests++;
      if (obs_wa[0] !== 12'h200) begin
        n_fail++;
        $display("FAIL single_waddr: got %h expected 200", obs_wa[0]);
      end
      if (obs_wd[0] !== 64'h7F7F020000100006) begin
        n_fail++;
        $display("FAIL single_wdata: got %h expected 7f7f020000100006", obs_wd[0]);
      end
    end
  endtask

  task automatic test_zero();
    int cyc;
    bit tmo;
    clear_obs();
    busy_cyc = 0;
    run_pass(12'h123, 12'h456, 11'd0, cyc, tmo);
    repeat (3) @(negedge clk);
    n_tests++;
    if (tmo || cyc !== 1) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d (tmo %0d) expected 1", cyc, tmo);
    end
    n_tests++;
    if (obs_rd.size() != 0 || obs_wa.size() != 0) begin
      n_fail++;
      $display("FAIL zero_access: got %0d reads %0d writes expected 0 0", obs_rd.size(), obs_wa.size());
    end
    n_tests++;
    if (busy_cyc !== 1) begin
      n_fail++;
      $display("FAIL zero_busy: got %0d busy cycles expected 1", busy_cyc);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit tmo;
    logic [11:0] exp_rd [4];
    exp_rd = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    prep(12'hFFE, 12'hFFF, 2);
    run_pass(12'hFFE, 12'hFFF, 11'd2, cyc, tmo);
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_rd.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_rcount: got %0d expected 4", obs_rd.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (obs_rd[k] !== exp_rd[k]) begin
          n_fail++;
          $display("FAIL wrap_raddr%0d: got %h expected %h", k, obs_rd[k], exp_rd[k]);
        end
      end
    end
    n_tests++;
    if (obs_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL wrap_wcount: got %0d expected %0d", obs_wa.size(), exp_wa.size());
    end else begin
      for (int k = 0; k < exp_wa.size(); k++) begin
        n_tests++;
        if ({obs_wa[k], obs_wd[k]} !== {exp_wa[k], exp_wd[k]}) begin
          n_fail++;
          $display("FAIL wrap_write%0d: got %h/%h expected %h/%h", k, obs_wa[k], obs_wd[k], exp_wa[k], exp_wd[k]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit tmo;
    prep(12'h100, 12'h300, 3);
    @(negedge clk);
    src_base = 12'h100;
    dst_base = 12'h300;
    pair_cnt = 11'd3;
    start = 1'b1;
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        // start during the DONE cycle must also be ignored
        src_base = 12'h5A0;
        dst_base = 12'h7B0;
        pair_cnt = 11'd2;
        start = 1'b1;
        tmo = 1'b0;
        break;
      end
      if (cyc == 3 || cyc == 8) begin
        src_base = 12'h500;
        dst_base = 12'h700;
        pair_cnt = 11'd5;
        start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tmo || cyc !== 13) begin
      n_fail++;
      $display("FAIL ign_latency: got %0d (tmo %0d) expected 13", cyc, tmo);
    end
    n_tests++;
    if (busy !== 1'b0 || obs_rd.size() != 6) begin
      n_fail++;
      $display("FAIL ign_extra_pass: got busy %b reads %0d expected 0 6", busy, obs_rd.size());
    end
    n_tests++;
    if (obs_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL ign_wcount: got %0d expected %0d", obs_wa.size(), exp_wa.size());
    end else begin
      for (int k = 0; k < exp_wa.size(); k++) begin
        n_tests++;
        if ({obs_wa[k], obs_wd[k]} !== {exp_wa[k], exp_wd[k]}) begin
          n_fail++;
          $display("FAIL ign_write%0d: got %h/%h expected %h/%h", k, obs_wa[k], obs_wd[k], exp_wa[k], exp_wd[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit tmo;
    logic [63:0] first_wd;
    prep(12'h040, 12'h400, 4);
    first_wd = exp_wd[0];
    @(negedge clk);
    src_base = 12'h040;
    dst_base = 12'h400;
    pair_cnt = 11'd4;
    start = 1'b1;
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (cyc == 7) begin
        // WAIT state of the second pair
        tmo = 1'b0;
        rst = 1'b0;
        break;
      end
    end
    #1;
    n_tests++;
    if (tmo || {rd_en, wr_en, done, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst_ctrl: got %b (tmo %0d) expected 0000", {rd_en, wr_en, done, busy}, tmo);
    end
    n_tests++;
    if ({rd_addr, wr_addr} !== 24'h0 || wr_din !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_rst_data: got %h/%h expected 0/0", {rd_addr, wr_addr}, wr_din);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (obs_wa.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_abort: got %0d writes busy %b expected 1 0", obs_wa.size(), busy);
    end else begin
      n_tests++;
      if (obs_wd[0] !== first_wd || obs_wa[0] !== 12'h400) begin
        n_fail++;
        $display("FAIL mid_rst_first: got %h/%h expected 400/%h", obs_wa[0], obs_wd[0], first_wd);
      end
    end
    prep(12'h040, 12'h400, 4);
    run_pass(12'h040, 12'h400, 11'd4, cyc, tmo);
    repeat (2) @(negedge clk);
    n_tests++;
    if (tmo || cyc !== 17) begin
      n_fail++;
      $display("FAIL rerun_latency: got %0d (tmo %0d) expected 17", cyc, tmo);
    end
    n_tests++;
    if (obs_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL rerun_wcount: got %0d expected %0d", obs_wa.size(), exp_wa.size());
    end else begin
      for (int k = 0; k < exp_wa.size(); k++) begin
        n_tests++;
        if ({obs_wa[k], obs_wd[k]} !== {exp_wa[k], exp_wd[k]}) begin
          n_fail++;
          $display("FAIL rerun_write%0d: got %h/%h expected %h/%h", k, obs_wa[k], obs_wd[k], exp_wa[k], exp_wd[k]);
        end
      end
    end
  endtask

  task automatic test_long();
    int cyc;
    bit tmo;
    int bad;
    prep(12'h800, 12'hA00, 64);
    busy_cyc = 0;
    busy_rise = 0;
    run_pass(12'h800, 12'hA00, 11'd64, cyc, tmo);
    repeat (3) @(negedge clk);
    n_tests++;
    if (tmo || cyc + 1 !== 258) begin
      n_fail++;
      $display("FAIL long_length: got %0d (tmo %0d) expected 258", cyc + 1, tmo);
    end
    n_tests++;
    if (busy_cyc !== 257 || busy_rise !== 1) begin
      n_fail++;
      $display("FAIL long_busy: got %0d cycles %0d rises expected 257 1", busy_cyc, busy_rise);
    end
    bad = 0;
    for (int k = 0; k < obs_rd.size(); k++) begin
      if (obs_rd[k] !== 12'h800 + 12'(k)) bad++;
    end
    n_tests++;
    if (obs_rd.size() != 128 || bad != 0) begin
      n_fail++;
      $display("FAIL long_reads: got %0d reads %0d wrong expected 128 0", obs_rd.size(), bad);
    end
    n_tests++;
    if (obs_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL long_wcount: got %0d expected %0d", obs_wa.size(), exp_wa.size());
    end else begin
      for (int k = 0; k < exp_wa.size(); k++) begin
        n_tests++;
        if ({obs_wa[k], obs_wd[k]} !== {exp_wa[k], exp_wd[k]}) begin
          n_fail++;
          $display("FAIL long_write%0d: got %h/%h expected %h/%h", k, obs_wa[k], obs_wd[k], exp_wa[k], exp_wd[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_long();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_pool.md
RELU_POOL -- requirements
Module: relu_pool

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: BRAM32k word address width.
REQ-002 SHALL have parameter LANES, default 8: signed 8-bit lanes per 64-bit word; lane i occupies bits [8i+7:8i].
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a pass; sampled only in IDLE.
REQ-006 SHALL have port src_base, input, ADDR_W: first BRAM32k source word address; latched on accepted start.
REQ-007 SHALL have port dst_base, input, ADDR_W: first destination word address; latched on accepted start.
REQ-008 SHALL have port pair_cnt, input, 11: number of word pairs to process; latched on accepted start.
REQ-009 SHALL have port rd_en, output, 1: source BRAM read enable.
REQ-010 SHALL have port rd_addr, output, ADDR_W: source read address.
REQ-011 SHALL have port rd_dout, input, 64: source read data, valid exactly one cycle after rd_en/rd_addr.
REQ-012 SHALL have port wr_en, output, 1: destination write enable.
REQ-013 SHALL have port wr_addr, output, ADDR_W: destination write address.
REQ-014 SHALL have port wr_din, output, 64: destination write data.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at pass completion.

Function
REQ-017 SHALL implement states IDLE, RDA, RDB, WAIT, WR, DONE.
REQ-018 IDLE: start=1 -> latch inputs, pair index j=0; pair_cnt=0 -> DONE, else -> RDA; start=0 -> stay.
REQ-019 RDA: rd_en=1, rd_addr=src_base+2j -> RDB.
REQ-020 RDB: rd_en=1, rd_addr=src_base+2j+1; capture rd_dout as word A -> WAIT.
REQ-021 WAIT: rd_en=0; capture rd_dout as word B -> WR.
REQ-022 WR: wr_en=1, wr_addr=dst_base+j, wr_din=per-lane result; then if j+1=pair_cnt -> DONE, else j<=j+1 -> RDA.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 Per-lane result = signed max(A[i],B[i]); result<0 -> 0x00; full 8-bit signed compare, no saturation needed.
REQ-025 Throughput: 4 cycles per pair; total pass length = 4*pair_cnt+2 cycles from start-accept edge to done-deassert.
REQ-026 rd_en, wr_en, done SHALL be 0 in every state not listed as driving them; wr_addr/wr_din hold last value outside WR.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W (4095+1 -> 0).
REQ-028 start while busy SHALL be ignored with no effect on the latched operands.
REQ-029 start in the same cycle as DONE SHALL be ignored; a new pass is accepted only in IDLE.
REQ-030 Source and destination ranges are independent; no overlap checking.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, j=0, rd_en=0, wr_en=0, done=0, busy=0, rd_addr=0, wr_addr=0, wr_din=0, captured words = 0.
REQ-032 Reset asserted mid-pass SHALL abort without further writes; the next pass requires a new start after rst=1.

Verification
REQ-033 pair_cnt=1, src_base=0x010, dst_base=0x200, word0=0x80_7F_01_FF_00_10_F0_05, word1=0x7F_80_02_FE_00_0F_F1_06 -> single write, wr_addr=0x200, wr_din=0x7F_7F_02_00_00_10_00_06; done at cycle 6.
REQ-034 pair_cnt=0 -> no rd_en/wr_en pulses, done one cycle after accept, busy high exactly one cycle.
REQ-035 src_base=0xFFE, dst_base=0xFFF, pair_cnt=2 -> reads 0xFFE,0xFFF,0x000,0x001; writes 0xFFF then 0x000.
REQ-036 start pulsed during pass with different operands -> ignored; write addresses/data match the first pass only.
REQ-037 rst deasserted-to-0 in the WAIT state of pair 2 of 4 -> all outputs 0 same cycle, no further writes; fresh start then runs a full correct pass.
REQ-038 pair_cnt=64 random data -> 64 writes matching reference model lane-by-lane, 258 cycles, busy continuous.
